// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with an on-the-fly key schedule.
// Each accepted state is XORed with the current round key and registered.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [0:3][0:3][7:0]   key_matrix,
    output logic                   key_loaded,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:3][0:3][7:0]   state_matrix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:3][0:3][7:0]   out_matrix,
    output logic [3:0]             out_round,
    output logic                   out_last
);

    localparam logic [3:0] NR_L = 4'(NR);

    logic [0:3][0:3][7:0] ck;
    logic [0:3][0:3][7:0] rk;
    logic [0:3][0:3][7:0] nrk;
    logic [3:0]           rc;
    logic [7:0]           rcon;
    logic                 accept;
    logic [31:0]          w  [0:3];
    logic [31:0]          nw [0:3];
    logic [31:0]          rot;
    logic [31:0]          t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign in_ready = key_loaded & ~key_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // Next round key: one full AES-128 expansion step from the current key.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w[c] = {rk[0][c], rk[1][c], rk[2][c], rk[3][c]};
        end
        rot = {w[3][23:0], w[3][31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]),  sbox(rot[7:0])} ^ {rcon, 24'h0};
        nw[0] = w[0] ^ t;
        nw[1] = w[1] ^ nw[0];
        nw[2] = w[2] ^ nw[1];
        nw[3] = w[3] ^ nw[2];
        nrk = '0;
        for (int c = 0; c < 4; c++) begin
            nrk[0][c] = nw[c][31:24];
            nrk[1][c] = nw[c][23:16];
            nrk[2][c] = nw[c][15:8];
            nrk[3][c] = nw[c][7:0];
        end
    end

    // Key registers: load, advance per accepted beat, wrap after round NR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck         <= '0;
            rk         <= '0;
            rc         <= 4'd0;
            rcon       <= 8'h01;
            key_loaded <= 1'b0;
        end else if (key_load) begin
            ck         <= key_matrix;
            rk         <= key_matrix;
            rc         <= 4'd0;
            rcon       <= 8'h01;
            key_loaded <= 1'b1;
        end else if (accept) begin
            if (rc == NR_L) begin
                rk   <= ck;
                rc   <= 4'd0;
                rcon <= 8'h01;
            end else begin
                rk   <= nrk;
                rc   <= rc + 4'd1;
                rcon <= xtime(rcon);
            end
        end
    end

    // Output register: capture on accept, clear valid once popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_matrix <= '0;
            out_round  <= 4'd0;
            out_last   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_matrix <= state_matrix ^ rk;
            out_round  <= rc;
            out_last   <= (rc == NR_L);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage using FIPS-197 vectors.
// Vectors are written in FIPS byte order and mapped to [row][col].
module tb_add_round_key_stage;

    typedef logic [0:3][0:3][7:0] mat_t;

    logic       clk;
    logic       rst;
    logic       key_load;
    mat_t       key_matrix;
    logic       key_loaded;
    logic       in_valid;
    logic       in_ready;
    mat_t       state_matrix;
    logic       out_valid;
    logic       out_ready;
    mat_t       out_matrix;
    logic [3:0] out_round;
    logic       out_last;

    int vecs = 0;
    int errs = 0;

    logic [127:0] rk_tab [0:10];

    add_round_key_stage #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_matrix   (key_matrix),
        .key_loaded   (key_loaded),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .state_matrix (state_matrix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_matrix   (out_matrix),
        .out_round    (out_round),
        .out_last     (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIPS byte n goes to row n%4, column n/4.
    function automatic mat_t to_mat(input logic [127:0] v);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = v[127 - 8*(r + 4*c) -: 8];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] S1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] O1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] S2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] O2 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] R2 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    initial begin
        rk_tab[0]  = K1;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset with a pending beat and no key.
        rst          = 1'b1;
        key_load     = 1'b0;
        key_matrix   = '0;
        in_valid     = 1'b1;
        state_matrix = to_mat(S1);
        out_ready    = 1'b1;
        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_key_loaded", 128'(key_loaded), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_matrix", out_matrix, 128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("nokey_in_ready", 128'(in_ready), 128'(0));
        chk("nokey_out_valid", 128'(out_valid), 128'(0));

        // Load the FIPS-197 cipher key.
        in_valid   = 1'b0;
        key_load   = 1'b1;
        key_matrix = to_mat(K1);
        tick();
        key_load = 1'b0;
        #1;
        chk("load_key_loaded", 128'(key_loaded), 128'(1));
        chk("load_in_ready", 128'(in_ready), 128'(1));

        // Round 0 on the FIPS plaintext.
        in_valid     = 1'b1;
        state_matrix = to_mat(S1);
        tick();
        chk("r0_valid", 128'(out_valid), 128'(1));
        chk("r0_matrix", out_matrix, to_mat(O1));
        chk("r0_round", 128'(out_round), 128'(0));
        chk("r0_last", 128'(out_last), 128'(0));

        // Zero states expose the round keys, streamed back to back.
        state_matrix = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("rk%0d_valid", i), 128'(out_valid), 128'(1));
            chk($sformatf("rk%0d_matrix", i), out_matrix, to_mat(rk_tab[i]));
            chk($sformatf("rk%0d_round", i), 128'(out_round), 128'(i));
            chk($sformatf("rk%0d_last", i), 128'(out_last),
                128'(i == 10 ? 1 : 0));
        end

        // Wrap to the cipher key without key_load, then rounds 1..2.
        for (int i = 0; i <= 2; i++) begin
            tick();
            chk($sformatf("wrap%0d_valid", i), 128'(out_valid), 128'(1));
            chk($sformatf("wrap%0d_matrix", i), out_matrix,
                to_mat(rk_tab[i]));
            chk($sformatf("wrap%0d_round", i), 128'(out_round), 128'(i));
        end

        // Backpressure for 3 cycles with a beat waiting.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            tick();
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_matrix", out_matrix, to_mat(rk_tab[2]));
            chk("bp_round", 128'(out_round), 128'(2));
        end
        out_ready = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            tick();
            chk($sformatf("resume%0d_matrix", i), out_matrix,
                to_mat(rk_tab[i]));
            chk($sformatf("resume%0d_round", i), 128'(out_round), 128'(i));
        end

        // key_load mid-block while round 4 output drains.
        key_load     = 1'b1;
        key_matrix   = to_mat(K2);
        state_matrix = to_mat(S2);
        #1;
        chk("kl_in_ready", 128'(in_ready), 128'(0));
        chk("kl_old_matrix", out_matrix, to_mat(rk_tab[4]));
        chk("kl_old_round", 128'(out_round), 128'(4));
        tick();
        key_load = 1'b0;
        #1;
        chk("kl_drained", 128'(out_valid), 128'(0));
        chk("kl_ready_again", 128'(in_ready), 128'(1));
        tick();
        chk("k2_r0_matrix", out_matrix, to_mat(O2));
        chk("k2_r0_round", 128'(out_round), 128'(0));
        state_matrix = '0;
        tick();
        chk("k2_r1_matrix", out_matrix, to_mat(R2));
        chk("k2_r1_round", 128'(out_round), 128'(1));

        // Pop with no new beat clears out_valid.
        in_valid = 1'b0;
        tick();
        chk("idle_valid", 128'(out_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
